// File: rtl/ins_fetch.sv
// ---------------------------------------------------------------------------
// ins_fetch : instruction fetch sequencer with PC, one-entry output slot and
//             valid/ready handshake toward decode.      Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ins_fetch #(
  parameter int unsigned             ADDR_W    = 16,
  parameter int unsigned             DATA_W    = 32,
  parameter logic [ADDR_W-1:0]       RESET_PC  = '0,
  parameter logic [DATA_W-1:0]       HALT_WORD = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [DATA_W-1:0] ins_out,
  output logic [ADDR_W-1:0] ins_pc,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  logic [1:0]        state,     state_nxt;
  logic [ADDR_W-1:0] pc,        pc_nxt;
  logic              valid_nxt;
  logic [DATA_W-1:0] out_nxt;
  logic [ADDR_W-1:0] ins_pc_nxt;
  logic [31:0]       count_nxt;

  logic slot_free;
  logic handshake;

  assign slot_free = !ins_valid || ins_ready;
  assign handshake = ins_valid && ins_ready;
  assign mem_addr  = pc;
  assign halted    = (state == HALT);

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    valid_nxt  = ins_valid;
    out_nxt    = ins_out;
    ins_pc_nxt = ins_pc;
    count_nxt  = fetch_count;
    case (state)
      IDLE: begin
        if (redirect_valid) pc_nxt = redirect_pc;
        if (handshake)      valid_nxt = 1'b0;
        if (start)          state_nxt = RUN;
      end
      RUN: begin
        if (redirect_valid) begin
          pc_nxt    = redirect_pc;
          valid_nxt = 1'b0;
        end else if (slot_free) begin
          out_nxt    = mem_data;
          ins_pc_nxt = pc;
          valid_nxt  = 1'b1;
          pc_nxt     = pc + ADDR_W'(1);
          count_nxt  = fetch_count + 32'd1;
          // The halt word itself is still handed to decode.
          if (mem_data == HALT_WORD) state_nxt = HALT;
        end
      end
      HALT: begin
        if (redirect_valid) begin
          pc_nxt    = redirect_pc;
          valid_nxt = 1'b0;
          state_nxt = RUN;
        end else begin
          if (handshake) valid_nxt = 1'b0;
          if (start)     state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      ins_valid   <= 1'b0;
      ins_out     <= '0;
      ins_pc      <= '0;
      fetch_count <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      ins_valid   <= valid_nxt;
      ins_out     <= out_nxt;
      ins_pc      <= ins_pc_nxt;
      fetch_count <= count_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ins_fetch.sv
// ---------------------------------------------------------------------------
// tb_ins_fetch : directed + randomized bench for ins_fetch against a
//                cycle-level behavioural model.        Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ins_fetch;

  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] mem_addr;
  logic [31:0] mem_data;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins_out;
  logic [15:0] ins_pc;
  logic        halted;
  logic [31:0] fetch_count;

  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];
  assign mem_data = mem[mem_addr];

  ins_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ins_valid      (ins_valid),
    .ins_ready      (ins_ready),
    .ins_out        (ins_out),
    .ins_pc         (ins_pc),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: fetching / halted flags, neither set means idle.
  bit          m_fetching, m_halted, m_valid;
  logic [15:0] m_pc, m_ipc;
  logic [31:0] m_out, m_count;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_fetching = 0; m_halted = 0; m_valid = 0;
      m_pc = 16'h0000; m_ipc = 16'h0000; m_out = 0; m_count = 0;
    end else if (m_fetching) begin
      if (redirect_valid) begin
        m_pc = redirect_pc; m_valid = 0;
      end else if (!m_valid || ins_ready) begin
        m_out = mem[m_pc]; m_ipc = m_pc; m_valid = 1;
        m_pc = m_pc + 16'd1; m_count = m_count + 1;
        if (m_out == HALT_W) begin m_fetching = 0; m_halted = 1; end
      end
    end else if (m_halted && redirect_valid) begin
      m_pc = redirect_pc; m_valid = 0; m_halted = 0; m_fetching = 1;
    end else begin
      if (redirect_valid) m_pc = redirect_pc;
      if (m_valid && ins_ready) m_valid = 0;
      if (start) begin m_fetching = 1; m_halted = 0; end
    end
  endtask

  task automatic check_all();
    check("mem_addr", {16'h0, mem_addr}, {16'h0, m_pc});
    check("ins_valid", {31'h0, ins_valid}, {31'h0, m_valid});
    check("halted", {31'h0, halted}, {31'h0, m_halted});
    check("fetch_count", fetch_count, m_count);
    if (m_valid) begin
      check("ins_out", ins_out, m_out);
      check("ins_pc", {16'h0, ins_pc}, {16'h0, m_ipc});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic load_program();
    mem[0] = 32'hA000_0000; mem[1] = 32'hA000_0001;
    mem[2] = 32'hA000_0002; mem[3] = HALT_W;
    mem[4] = 32'hA000_0004; mem[5] = HALT_W;
  endtask

  task automatic do_reset();
    rst = 1; start = 0; redirect_valid = 0; redirect_pc = 0;
    tick();
    rst = 0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
    load_program();
    rst = 1; start = 0; redirect_valid = 0; redirect_pc = 0; ins_ready = 0;
    #1;
    tick(); tick();
    check("reset_valid", {31'h0, ins_valid}, 32'h0);
    check("reset_pc", {16'h0, mem_addr}, 32'h0);
    check("reset_count", fetch_count, 32'h0);

    // Straight run to halt
    rst = 0; start = 1; ins_ready = 1;
    tick();
    start = 0;
    tick(); check("run_w0", ins_out, 32'hA000_0000);
    tick(); check("run_w1", ins_out, 32'hA000_0001);
    tick(); check("run_w2", ins_out, 32'hA000_0002);
    tick(); check("run_halt_word", ins_out, HALT_W);
    check("run_halt_pc", {16'h0, ins_pc}, 32'd3);
    check("run_halted", {31'h0, halted}, 32'd1);
    check("run_count", fetch_count, 32'd4);
    check("run_addr", {16'h0, mem_addr}, 32'd4);
    tick(); tick();
    check("halt_drained", {31'h0, ins_valid}, 32'h0);
    check("halt_no_fetch", fetch_count, 32'd4);

    // Stall on A1 for three cycles
    do_reset();
    ins_ready = 1; start = 1;
    tick(); start = 0;
    tick(); tick();
    ins_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_out", ins_out, 32'hA000_0001);
      check("stall_addr", {16'h0, mem_addr}, 32'd2);
    end
    ins_ready = 1;
    tick(); check("stall_next", ins_out, 32'hA000_0002);

    // Redirect while A1 held
    do_reset();
    mem[16'h0100] = 32'hC000_0100;
    ins_ready = 1; start = 1;
    tick(); start = 0;
    tick(); tick();
    redirect_valid = 1; redirect_pc = 16'h0100;
    tick(); redirect_valid = 0;
    check("redir_flush", {31'h0, ins_valid}, 32'h0);
    check("redir_count", fetch_count, 32'd2);
    tick();
    check("redir_target_pc", {16'h0, ins_pc}, 32'h0100);
    check("redir_target_out", ins_out, 32'hC000_0100);

    // Address wrap
    mem[16'hFFFE] = 32'hB000_0000; mem[16'hFFFF] = 32'hB000_0001; mem[0] = 32'hB000_0002;
    redirect_valid = 1; redirect_pc = 16'hFFFE;
    tick(); redirect_valid = 0;
    tick(); check("wrap_pc0", {16'h0, ins_pc}, 32'hFFFE);
    tick(); check("wrap_pc1", {16'h0, ins_pc}, 32'hFFFF);
    tick(); check("wrap_pc2", {16'h0, ins_pc}, 32'h0000);
    check("wrap_out2", ins_out, 32'hB000_0002);
    load_program();

    // Halt, resume with start, then redirect out of a second halt
    do_reset();
    ins_ready = 1; start = 1;
    tick(); start = 0;
    for (int i = 0; i < 5; i++) tick();
    check("resume_halted", {31'h0, halted}, 32'd1);
    start = 1; tick(); start = 0;
    tick(); check("resume_pc", {16'h0, ins_pc}, 32'd4);
    tick(); check("rehalt", {31'h0, halted}, 32'd1);
    redirect_valid = 1; redirect_pc = 16'h0002;
    tick(); redirect_valid = 0;
    check("halt_redir_halted", {31'h0, halted}, 32'd0);
    tick(); check("halt_redir_pc", {16'h0, ins_pc}, 32'd2);

    // Reset mid-stream
    do_reset();
    ins_ready = 0; start = 1;
    tick(); start = 0;
    tick();
    rst = 1; tick(); rst = 0;
    check("midrst_valid", {31'h0, ins_valid}, 32'h0);
    check("midrst_count", fetch_count, 32'h0);
    check("midrst_pc", {16'h0, mem_addr}, 32'h0);
    tick(); tick();
    check("midrst_idle", fetch_count, 32'h0);

    // Randomized phase
    for (int i = 0; i < 65536; i++)
      mem[i] = ($urandom_range(0, 15) == 0) ? HALT_W : $urandom;
    for (int c = 0; c < 4000; c++) begin
      rst            = ($urandom_range(0, 249) == 0);
      start          = ($urandom_range(0, 7) == 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 64));
      ins_ready      = ($urandom_range(0, 9) < 7);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
